// File: rtl/mul_pipe_pkg.sv
// Shared constants and types for the pipelined multiplier wrapper.
package mul_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        MUL_OP_MUL   = 2'b00,
        MUL_OP_MULH  = 2'b01,
        MUL_OP_MULHU = 2'b10,
        MUL_OP_RSVD  = 2'b11
    } mul_op_e;

    // Operands and op code held in the first pipeline stage
    typedef struct packed {
        mul_op_e         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mul_req_t;

endpackage

// File: rtl/mul_pipe_if.sv
// Valid/ready request and result channels of the multiplier pipeline.
interface mul_pipe_if;
    import mul_pipe_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_src1, in_src2, flush, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, flush, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/multiplier.sv
// Combinational 32x32 signed multiplier: radix-4 Booth recoding, partial products summed mod 2^64.
module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    logic [63:0] a_ext;
    logic [32:0] b_ext;
    logic [2:0]  trip;
    logic [63:0] pp;
    logic [63:0] acc;

    assign a_ext = {{32{a[31]}}, a};
    assign b_ext = {b, 1'b0};

    // Each overlapping bit triplet of B selects 0, +-A or +-2A at weight 4^i
    always_comb begin
        acc  = '0;
        trip = '0;
        pp   = '0;
        for (int i = 0; i < 16; i++) begin
            trip = b_ext[2*i +: 3];
            unique case (trip)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
    end

    assign p = acc;

endmodule

// File: rtl/mul_pipe.sv
// Two-stage valid/ready wrapper around the signed multiplier producing MUL/MULH/MULHU results.
module mul_pipe
    import mul_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mul_pipe_if.slave   bus
);

    logic              s1_valid;
    mul_req_t          s1_q;
    logic              s2_valid;
    logic [XLEN-1:0]   s2_result;
    logic              s1_ready;
    logic              s2_ready;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   hi_unsigned_c;
    logic [XLEN-1:0]   result_c;

    assign s2_ready    = !s2_valid || bus.out_ready;
    assign s1_ready    = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready && !bus.flush;

    multiplier u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .p (prod)
    );

    // Unsigned high word: add back B for negative A and A for negative B (mod 2^32)
    always_comb begin
        hi_unsigned_c = prod[2*XLEN-1:XLEN]
                      + (s1_q.a[XLEN-1] ? s1_q.b : '0)
                      + (s1_q.b[XLEN-1] ? s1_q.a : '0);
        result_c = prod[XLEN-1:0];
        unique case (s1_q.op)
            MUL_OP_MULH:  result_c = prod[2*XLEN-1:XLEN];
            MUL_OP_MULHU: result_c = hi_unsigned_c;
            default:      result_c = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= result_c;
                end
            end
            if (s1_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= '{op: mul_op_e'(bus.in_op), a: bus.in_src1, b: bus.in_src2};
                end
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed and scoreboarded checks of the two-stage multiplier pipeline.
module tb_mul_pipe;
    import mul_pipe_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mul_pipe_if bus ();

    mul_pipe u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ps;
        logic [63:0] pu;
        ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            2'b01:   return ps[63:32];
            2'b10:   return pu[63:32];
            default: return ps[31:0];
        endcase
    endfunction

    // One op through an empty pipe; result must show after the second edge
    task automatic issue_one(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_src1   = a;
        bus.in_src2   = b;
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick;
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        tick;
        #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_result"}, bus.out_result, exp);
        tick;
        #1;
        check({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_stream(input int cycles, input int reset_at);
        logic acc;
        logic [31:0] exp;
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_op     = 2'($urandom_range(0, 3));
            bus.in_src1   = pick_operand();
            bus.in_src2   = pick_operand();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (c == reset_at) begin
                resetn = 1'b0;
                #1;
                check("async_rst_valid", 32'(bus.out_valid), 32'd0);
                check("async_rst_result", bus.out_result, 32'd0);
                sb_q.delete();
                bus.in_valid = 1'b0;
                tick;
                tick;
                resetn = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    check("post_rst_stray", 32'(bus.out_valid), 32'd0);
                    tick;
                end
                check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
                continue;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
                else check("sb_result", bus.out_result, sb_q.pop_front());
            end
            acc = bus.in_valid && bus.in_ready;
            exp = ref_mul(bus.in_op, bus.in_src1, bus.in_src2);
            tick;
            if (acc) sb_q.push_back(exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) begin
            #1;
            if (bus.out_valid) check("sb_drain", bus.out_result, sb_q.pop_front());
            tick;
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int got;
        logic acc;
        logic [31:0] bp_exp [4];

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        resetn = 1'b1;
        tick;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        issue_one("mul_neg", 2'b00, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA);
        issue_one("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue_one("mulhu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue_one("mulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_one("rsvd_as_mul", 2'b11, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA);
        issue_one("mulhu_min2", 2'b10, 32'h8000_0000, 32'd2, 32'h0000_0001);
        issue_one("mulh_min2", 2'b01, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        issue_one("mul_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780);

        // Back-pressure: four MULs (i+1)*10 against a stalled sink
        bp_exp = '{32'd10, 32'd20, 32'd30, 32'd40};
        idx = 0;
        bus.out_ready = 1'b0;
        bus.in_op     = 2'b00;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_src1  = 32'(idx + 1);
            bus.in_src2  = 32'd10;
            #1;
            if (c >= 2) begin
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_result", bus.out_result, 32'd10);
            end
            acc = bus.in_valid && bus.in_ready;
            tick;
            if (acc) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_src1  = 32'(idx + 1);
            bus.in_src2  = 32'd10;
            #1;
            if (bus.out_valid) begin
                check("bp_order", bus.out_result, bp_exp[got]);
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 32'(got), 32'd4);

        // Flush with both stages full and a pending request
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.in_src1  = 32'(5 + idx);
            bus.in_src2  = 32'(5 + idx);
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick;
            if (acc) idx++;
        end
        check("fl_filled", 32'(idx), 32'd2);
        bus.in_src1 = 32'd9;
        bus.in_src2 = 32'd9;
        bus.flush   = 1'b1;
        #1;
        check("fl_in_ready", 32'(bus.in_ready), 32'd0);
        check("fl_full_before", 32'(bus.out_valid), 32'd1);
        tick;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        tick;
        check("fl_s1_empty", 32'(bus.out_valid), 32'd0);
        issue_one("fl_after", 2'b00, 32'd7, 32'd6, 32'h0000_002A);

        // Random stream against the 64-bit reference, with a mid-stream reset
        run_stream(150, 90);
        run_stream(100, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
